// File: rtl/dmem_pkg.sv
// Shared types, byte-enable encodings and the access legality check for the
// data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   localparam int DMEM_DEPTH = 2048;

   // An access faults on an unknown size or a misaligned half/word.
   function automatic logic access_fault(input logic [3:0] be, input logic [1:0] lo);
      case (be)
         BE_BYTE: return 1'b0;
         BE_HALF: return lo[0];
         BE_WORD: return (lo != 2'b00);
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-wide store with four lane write enables and a combinational 4-byte
// read port starting at idx; lane indices wrap at DEPTH. Not reset.
module dmem_byte_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = DMEM_DEPTH
) (
   input  logic                     clk,
   input  logic [$clog2(DEPTH)-1:0] idx,
   input  logic [3:0]               wr_be,
   input  logic [31:0]              wr_data,
   output logic [31:0]              rd_data
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] lane_idx [4];

   for (genvar k = 0; k < 4; k++) begin : g_lane
      assign lane_idx[k] = idx + AW'(k);
   end

   // Commit each enabled lane to its (wrapped) byte location.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (wr_be[k]) mem[lane_idx[k]] <= wr_data[8*k +: 8];
      end
   end

   // Gather four consecutive bytes, little-endian.
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < 4; k++) begin
         rd_data[8*k +: 8] = mem[lane_idx[k]];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder on the shared dmem_data bus: req/ready handshake with
// WAIT_STATES wait cycles, byte/half/word access with fault detection.
//
// state | meaning
// IDLE  | waiting for req; request fields are latched on acceptance
// WAIT  | counting down wait states, bus released
// RESP  | ready high for one cycle; read drives bus, write commits at its end
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH       = DMEM_DEPTH,
   parameter int WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [3:0]  byte_en,
   input  logic [31:0] address,
   inout  wire  [31:0] dmem_data,
   output logic        ready,
   output logic        fault
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t        state;
   logic [3:0]    wait_cnt;
   logic          we_q;
   logic [3:0]    be_q;
   logic [AW-1:0] idx_q;
   logic          bad_q;
   logic          bad_now;
   logic [3:0]    wr_be;
   logic [31:0]   rd_word;
   logic [31:0]   rd_masked;
   logic          drive_en;
   logic          unused_addr;

   // Upper address bits only alias the store.
   assign unused_addr = ^address[31:AW];

   assign bad_now = access_fault(byte_en, address[1:0]);

   // Handshake FSM with the wait-state down-counter; ready/fault registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         ready    <= 1'b0;
         fault    <= 1'b0;
         wait_cnt <= 4'd0;
         we_q     <= 1'b0;
         be_q     <= 4'd0;
         idx_q    <= '0;
         bad_q    <= 1'b0;
      end else begin
         ready <= 1'b0;
         fault <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  we_q  <= we;
                  be_q  <= byte_en;
                  idx_q <= address[AW-1:0];
                  bad_q <= bad_now;
                  if (WAIT_STATES > 0) begin
                     state    <= WAIT;
                     wait_cnt <= WAIT_LOAD;
                  end else begin
                     state <= RESP;
                     ready <= 1'b1;
                     fault <= bad_now;
                  end
               end
            end
            WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state <= RESP;
                  ready <= 1'b1;
                  fault <= bad_q;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Write lanes are gated by rst_n so a reset edge never commits data.
   assign wr_be = (rst_n && state == RESP && we_q && !bad_q) ? be_q : 4'b0000;

   dmem_byte_array #(.DEPTH(DEPTH)) u_array (
      .clk     (clk),
      .idx     (idx_q),
      .wr_be   (wr_be),
      .wr_data (dmem_data),
      .rd_data (rd_word)
   );

   // Disabled lanes read as zero so the front-end can extend from bit 0.
   always_comb begin
      rd_masked = '0;
      for (int k = 0; k < 4; k++) begin
         rd_masked[8*k +: 8] = be_q[k] ? rd_word[8*k +: 8] : 8'h00;
      end
   end

   assign drive_en  = (state == RESP) && !we_q && !bad_q;
   assign dmem_data = drive_en ? rd_masked : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (0, 3 and 2 wait states)
// on separate pulled-up buses, so a released bus reads all ones.
module tb_dmem_responder;

   typedef struct {
      int          sel;
      logic        flt;
      logic        rd;
      logic [31:0] data;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  req_v = '0;
   logic [2:0]  we_v = '0;
   logic [2:0]  oe_v = '0;
   logic [2:0]  rdy_v;
   logic [2:0]  flt_v;
   logic [3:0]  be_a   [3];
   logic [31:0] addr_a [3];
   logic [31:0] wd_a   [3];

   tri1 [31:0] bus0;
   tri1 [31:0] bus1;
   tri1 [31:0] bus2;

   assign bus0 = oe_v[0] ? wd_a[0] : 32'hzzzz_zzzz;
   assign bus1 = oe_v[1] ? wd_a[1] : 32'hzzzz_zzzz;
   assign bus2 = oe_v[2] ? wd_a[2] : 32'hzzzz_zzzz;

   exp_t sb[$];
   int   ncmp = 0;
   int   nfail = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(2048), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst_n(rst_n), .req(req_v[0]), .we(we_v[0]), .byte_en(be_a[0]),
      .address(addr_a[0]), .dmem_data(bus0), .ready(rdy_v[0]), .fault(flt_v[0]));

   dmem_responder #(.DEPTH(2048), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .rst_n(rst_n), .req(req_v[1]), .we(we_v[1]), .byte_en(be_a[1]),
      .address(addr_a[1]), .dmem_data(bus1), .ready(rdy_v[1]), .fault(flt_v[1]));

   dmem_responder #(.DEPTH(2048), .WAIT_STATES(2)) u_ws2 (
      .clk(clk), .rst_n(rst_n), .req(req_v[2]), .we(we_v[2]), .byte_en(be_a[2]),
      .address(addr_a[2]), .dmem_data(bus2), .ready(rdy_v[2]), .fault(flt_v[2]));

   function automatic logic [31:0] rd_bus(input int sel);
      case (sel)
         0:       return bus0;
         1:       return bus1;
         default: return bus2;
      endcase
   endfunction

   function automatic int ws_of(input int sel);
      case (sel)
         0:       return 0;
         1:       return 3;
         default: return 2;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete request on instance sel; expectations go through the scoreboard.
   task automatic xact(input int sel, input logic w, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic ef, input logic [31:0] ed);
      exp_t e;
      int   cyc;
      bit   got;
      e.sel  = sel;
      e.flt  = ef;
      e.rd   = !w;
      e.data = ef ? 32'hFFFF_FFFF : ed;
      e.lat  = ws_of(sel) + 1;
      sb.push_back(e);
      @(posedge clk); #1;
      req_v[sel] = 1'b1;
      we_v[sel]  = w;
      be_a[sel]  = be;
      addr_a[sel] = a;
      wd_a[sel]  = d;
      oe_v[sel]  = w;
      @(posedge clk);
      cyc = 0;
      got = 0;
      while (!got && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (rdy_v[sel]) got = 1;
         else if (!w) check("bus_released_in_wait", rd_bus(sel), 32'hFFFF_FFFF);
      end
      e = sb.pop_front();
      check("ready_seen", {31'b0, got}, 32'd1);
      check("latency", cyc, e.lat);
      check("fault", {31'b0, flt_v[e.sel]}, {31'b0, e.flt});
      if (e.rd) check("read_bus", rd_bus(e.sel), e.data);
      @(posedge clk); #1;
      req_v[sel] = 1'b0;
      oe_v[sel]  = 1'b0;
      we_v[sel]  = ~w;
      addr_a[sel] = $urandom;
      @(negedge clk);
      check("ready_one_cycle", {31'b0, rdy_v[sel]}, 32'd0);
      check("fault_cleared", {31'b0, flt_v[sel]}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         be_a[i] = 4'd0;
         addr_a[i] = 32'd0;
         wd_a[i] = 32'd0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("reset_ready", {31'b0, rdy_v[i]}, 32'd0);
         check("reset_fault", {31'b0, flt_v[i]}, 32'd0);
         check("reset_bus", rd_bus(i), 32'hFFFF_FFFF);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Zero wait states: word, byte, half accesses.
      xact(0, 1'b1, 4'b1111, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
      xact(0, 1'b0, 4'b1111, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);
      xact(0, 1'b1, 4'b0001, 32'h13, 32'h0000_007F, 1'b0, 32'h0);
      xact(0, 1'b0, 4'b1111, 32'h10, 32'h0, 1'b0, 32'h7FAD_BEEF);
      xact(0, 1'b0, 4'b0011, 32'h12, 32'h0, 1'b0, 32'h0000_7FAD);
      xact(0, 1'b0, 4'b0001, 32'h11, 32'h0, 1'b0, 32'h0000_00BE);

      // Faulting accesses leave the store alone and keep the bus released.
      xact(0, 1'b1, 4'b1111, 32'h20, 32'hCAFE_F00D, 1'b0, 32'h0);
      xact(0, 1'b0, 4'b1111, 32'h11, 32'h0, 1'b1, 32'h0);
      xact(0, 1'b1, 4'b0011, 32'h21, 32'h0000_1234, 1'b1, 32'h0);
      xact(0, 1'b0, 4'b0101, 32'h10, 32'h0, 1'b1, 32'h0);
      xact(0, 1'b1, 4'b0101, 32'h10, 32'h5555_5555, 1'b1, 32'h0);
      xact(0, 1'b0, 4'b1111, 32'h20, 32'h0, 1'b0, 32'hCAFE_F00D);
      xact(0, 1'b0, 4'b1111, 32'h10, 32'h0, 1'b0, 32'h7FAD_BEEF);

      // High address bits alias into the store.
      xact(0, 1'b1, 4'b1111, 32'h1001_07FC, 32'h1122_3344, 1'b0, 32'h0);
      xact(0, 1'b0, 4'b1111, 32'h0000_07FC, 32'h0, 1'b0, 32'h1122_3344);
      xact(0, 1'b0, 4'b0001, 32'h0000_07FF, 32'h0, 1'b0, 32'h0000_0011);
      xact(0, 1'b0, 4'b0011, 32'h0000_07FE, 32'h0, 1'b0, 32'h0000_1122);

      // Three wait states.
      xact(1, 1'b1, 4'b1111, 32'h10, 32'hA5A5_5A5A, 1'b0, 32'h0);
      xact(1, 1'b0, 4'b1111, 32'h10, 32'h0, 1'b0, 32'hA5A5_5A5A);
      xact(1, 1'b0, 4'b1111, 32'h12, 32'h0, 1'b1, 32'h0);

      // Two wait states, then a write aborted by reset in its second WAIT cycle.
      xact(2, 1'b1, 4'b1111, 32'h40, 32'h0102_0304, 1'b0, 32'h0);
      @(posedge clk); #1;
      req_v[2] = 1'b1;
      we_v[2] = 1'b1;
      be_a[2] = 4'b1111;
      addr_a[2] = 32'h40;
      wd_a[2] = 32'hFFFF_0000;
      oe_v[2] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_wait1_ready", {31'b0, rdy_v[2]}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_wait2_ready", {31'b0, rdy_v[2]}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      req_v[2] = 1'b0;
      oe_v[2] = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("abort_no_ready", {31'b0, rdy_v[2]}, 32'd0);
         check("abort_no_fault", {31'b0, flt_v[2]}, 32'd0);
      end
      xact(2, 1'b0, 4'b1111, 32'h40, 32'h0, 1'b0, 32'h0102_0304);
      xact(0, 1'b0, 4'b1111, 32'h10, 32'h0, 1'b0, 32'h7FAD_BEEF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
